// File: rtl/gate_sequencer.sv
// Gate-array phase sequencer: sync, prime, ready-wait and step phases
// over a masked set of gates, with ready timeout, abort and step count.
module gate_sequencer #(
  parameter int GATE_NUMBER = 8,
  parameter int STEP_W      = 16,
  parameter int TIMEOUT_W   = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [STEP_W-1:0]      i_num_steps,
  input  logic [TIMEOUT_W-1:0]   i_timeout,
  input  logic [GATE_NUMBER-1:0] i_gate_en,
  input  logic [GATE_NUMBER-1:0] i_tx_ready,
  input  logic [GATE_NUMBER-1:0] i_rx_ready,
  output logic                   o_gen_sync,
  output logic                   o_tx_start,
  output logic                   o_rx_pull,
  output logic                   o_clock,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [GATE_NUMBER-1:0] o_stall_gates,
  output logic [STEP_W-1:0]      o_step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_STEP,
    S_DONE
  } state_t;

  state_t                 state;
  logic [STEP_W-1:0]      num_steps_q;
  logic [TIMEOUT_W-1:0]   timeout_q;
  logic [TIMEOUT_W-1:0]   timer;
  logic [GATE_NUMBER-1:0] gate_en_q;

  logic [GATE_NUMBER-1:0] pair_rdy;
  logic                   all_ready;
  logic                   expired;
  logic                   last_step;
  logic [STEP_W-1:0]      count_inc;

  // Disabled gates count as ready, so an empty mask never blocks.
  assign pair_rdy  = i_tx_ready & i_rx_ready;
  assign all_ready = &(pair_rdy | ~gate_en_q);
  assign expired   = (timeout_q != '0) &&
                     (timer == timeout_q - TIMEOUT_W'(1));
  assign count_inc = o_step_count + STEP_W'(1);
  assign last_step = (num_steps_q != '0) &&
                     (count_inc == num_steps_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      num_steps_q   <= '0;
      timeout_q     <= '0;
      gate_en_q     <= '0;
      timer         <= '0;
      o_timeout     <= 1'b0;
      o_stall_gates <= '0;
      o_step_count  <= '0;
    end else if (state != S_IDLE && i_abort) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state         <= S_PRIME;
            num_steps_q   <= i_num_steps;
            timeout_q     <= i_timeout;
            gate_en_q     <= i_gate_en;
            o_step_count  <= '0;
            o_timeout     <= 1'b0;
            o_stall_gates <= '0;
          end
        end
        S_PRIME: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (all_ready) begin
            state <= S_STEP;
          end else if (expired) begin
            state         <= S_IDLE;
            o_timeout     <= 1'b1;
            o_stall_gates <= gate_en_q & ~pair_rdy;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        S_STEP: begin
          o_step_count <= count_inc;
          timer        <= '0;
          state        <= last_step ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gen_sync = (state == S_IDLE);
  assign o_tx_start = (state == S_PRIME) || (state == S_STEP);
  assign o_rx_pull  = (state == S_STEP);
  assign o_clock    = (state == S_STEP);
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: directed scenarios plus randomized
// sequences against a phase-by-phase behavioural model.
module tb_gate_sequencer;

  localparam int GN = 8;
  localparam int SW = 4;
  localparam int TW = 12;

  localparam int P_IDLE  = 0;
  localparam int P_PRIME = 1;
  localparam int P_WAIT  = 2;
  localparam int P_STEP  = 3;
  localparam int P_DONE  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic [SW-1:0] i_num_steps;
  logic [TW-1:0] i_timeout;
  logic [GN-1:0] i_gate_en;
  logic [GN-1:0] i_tx_ready;
  logic [GN-1:0] i_rx_ready;
  logic          o_gen_sync;
  logic          o_tx_start;
  logic          o_rx_pull;
  logic          o_clock;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;
  logic [GN-1:0] o_stall_gates;
  logic [SW-1:0] o_step_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [SW-1:0] e_cnt;
  logic          e_to;
  logic [GN-1:0] e_stall;

  gate_sequencer #(
    .GATE_NUMBER(GN),
    .STEP_W     (SW),
    .TIMEOUT_W  (TW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_num_steps  (i_num_steps),
    .i_timeout    (i_timeout),
    .i_gate_en    (i_gate_en),
    .i_tx_ready   (i_tx_ready),
    .i_rx_ready   (i_rx_ready),
    .o_gen_sync   (o_gen_sync),
    .o_tx_start   (o_tx_start),
    .o_rx_pull    (o_rx_pull),
    .o_clock      (o_clock),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_stall_gates(o_stall_gates),
    .o_step_count (o_step_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // {gen_sync, tx_start, rx_pull, clock, busy, done} per phase
  function automatic logic [5:0] strobes(input int ph);
    case (ph)
      P_IDLE:  return 6'b100000;
      P_PRIME: return 6'b010010;
      P_WAIT:  return 6'b000010;
      P_STEP:  return 6'b011110;
      default: return 6'b000011;
    endcase
  endfunction

  task automatic check_all(input string tag, input int ph);
    chk({tag, ".strb"},
        32'({o_gen_sync, o_tx_start, o_rx_pull,
             o_clock, o_busy, o_done}),
        32'(strobes(ph)));
    chk({tag, ".cnt"}, 32'(o_step_count), 32'(e_cnt));
    chk({tag, ".to"}, 32'(o_timeout), 32'(e_to));
    chk({tag, ".stall"}, 32'(o_stall_gates), 32'(e_stall));
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // mode 0 all ready, 1 random, 2 gate1 never ready,
  // 3 gate2 tx never ready, 4 ready from c5, 5 ready before c3
  task automatic get_ready(input int mode, input int c,
                           output logic [GN-1:0] tx,
                           output logic [GN-1:0] rx);
    tx = '1;
    rx = '1;
    case (mode)
      1: begin
        if ($urandom % 4 == 0) tx = GN'($urandom);
        if ($urandom % 4 == 0) rx = GN'($urandom);
      end
      2: begin
        tx = 8'hFD;
        rx = 8'hFD;
      end
      3: tx = 8'hFB;
      4: if (c < 5) begin
        tx = '0;
        rx = '0;
      end
      5: if (c >= 3) tx = '0;
      default: ;
    endcase
  endtask

  task automatic run_seq(input logic [SW-1:0] ns,
                         input logic [TW-1:0] to,
                         input logic [GN-1:0] en,
                         input int mode,
                         input int abort_at,
                         input string tag);
    int c;
    int ph;
    int nxt;
    int waited;
    logic [GN-1:0] tx;
    logic [GN-1:0] rx;
    get_ready(mode, 0, tx, rx);
    i_tx_ready  = tx;
    i_rx_ready  = rx;
    i_num_steps = ns;
    i_timeout   = to;
    i_gate_en   = en;
    i_start     = 1'b1;
    i_abort     = 1'($urandom % 2);
    tick();
    c       = 1;
    ph      = P_PRIME;
    waited  = 0;
    e_cnt   = '0;
    e_to    = 1'b0;
    e_stall = '0;
    i_abort = 1'b0;
    check_all(tag, ph);
    while (ph != P_IDLE) begin
      if (c > 3000) begin
        chk({tag, ".hang"}, 32'(ph), 32'(P_IDLE));
        break;
      end
      get_ready(mode, c, tx, rx);
      i_tx_ready  = tx;
      i_rx_ready  = rx;
      i_start     = 1'($urandom % 2);
      i_num_steps = SW'($urandom);
      i_timeout   = TW'($urandom);
      i_gate_en   = GN'($urandom);
      nxt = ph;
      if (c == abort_at) begin
        i_abort = 1'b1;
        nxt     = P_IDLE;
      end else begin
        case (ph)
          P_PRIME: begin
            waited = 0;
            nxt    = P_WAIT;
          end
          P_WAIT: begin
            waited++;
            if (&((tx & rx) | ~en)) begin
              nxt = P_STEP;
            end else if (to != 0 && waited == int'(to)) begin
              nxt     = P_IDLE;
              e_to    = 1'b1;
              e_stall = en & ~(tx & rx);
            end
          end
          P_STEP: begin
            e_cnt  = SW'(e_cnt + 1);
            waited = 0;
            nxt = (ns != 0 && e_cnt == ns) ? P_DONE : P_WAIT;
          end
          default: nxt = P_IDLE;
        endcase
      end
      tick();
      c++;
      i_abort = 1'b0;
      ph = nxt;
      check_all(tag, ph);
    end
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      i_start = 1'b0;
      i_abort = 1'($urandom % 2);
      tick();
      check_all("idle", P_IDLE);
    end
    i_abort = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_num_steps = '0;
    i_timeout   = '0;
    i_gate_en   = '0;
    i_tx_ready  = '0;
    i_rx_ready  = '0;
    e_cnt       = '0;
    e_to        = 1'b0;
    e_stall     = '0;
    repeat (2) tick();
    check_all("reset", P_IDLE);
    i_rst = 1'b0;
    tick();
    check_all("reset.rel", P_IDLE);

    run_seq(4'd3, 12'd0, 8'hFF, 0, -1, "t2");
    idle_gap(2);

    i_start     = 1'b1;
    i_num_steps = 4'd2;
    i_timeout   = '0;
    i_gate_en   = 8'hFF;
    i_tx_ready  = '0;
    i_rx_ready  = '1;
    tick();
    i_start = 1'b0;
    e_cnt   = '0;
    e_to    = 1'b0;
    e_stall = '0;
    check_all("rst.prime", P_PRIME);
    tick();
    check_all("rst.wait", P_WAIT);
    #3 i_rst = 1'b1;
    #1;
    check_all("rst.async", P_IDLE);
    #2 i_rst = 1'b0;
    tick();
    check_all("rst.after", P_IDLE);

    run_seq(4'd2, 12'd0, 8'h05, 2, -1, "t3");
    idle_gap(1);
    run_seq(4'd2, 12'd4, 8'hFF, 3, -1, "t4");
    idle_gap(2);
    run_seq(4'd1, 12'd4, 8'hFF, 4, -1, "t5");
    idle_gap(1);
    run_seq(4'd3, 12'd0, 8'hFF, 5, 6, "t5ab");
    idle_gap(2);
    run_seq(4'd0, 12'd0, 8'hFF, 0, 40, "t6");
    idle_gap(1);

    for (int n = 0; n < 60; n++) begin
      logic [SW-1:0] ns;
      logic [TW-1:0] to;
      logic [GN-1:0] en;
      int ab;
      ns = SW'($urandom);
      to = TW'($urandom % 6);
      en = ($urandom % 8 == 0) ? '0 : GN'($urandom);
      if (ns == 0) ab = $urandom_range(1, 50);
      else if ($urandom % 4 == 0) ab = $urandom_range(1, 30);
      else ab = -1;
      run_seq(ns, to, en, 1, ab, "rnd");
      idle_gap($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_sequencer.md
Name: gate_sequencer

Overview:
Parametrised successor to the gate-array control FSM. Sequences sync, transmit-prime and receive-pull phases across GATE_NUMBER gates for a programmable number of steps, with a per-gate enable mask, a ready-wait timeout with stalled-gate capture, abort, and done/busy status. Sits between the test controller and the gate array. Drives the gates' sync/start/pull strobes and the gate clock.

Parameters:
GATE_NUMBER, 8, number of gates.
STEP_W, 16, width of the step count and step counter.
TIMEOUT_W, 12, width of the ready-wait timeout.

Ports:
i_clk  in  1  single clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_start  in  1  begin a sequence; honoured only in IDLE.
i_abort  in  1  terminate the sequence; honoured in any non-IDLE state.
i_num_steps  in  STEP_W  number of steps; 0 = free-run until abort.
i_timeout  in  TIMEOUT_W  maximum WAIT cycles without ready; 0 = no timeout.
i_gate_en  in  GATE_NUMBER  gate enable mask; disabled gates are ignored.
i_tx_ready  in  GATE_NUMBER  per-gate TX ready.
i_rx_ready  in  GATE_NUMBER  per-gate RX ready.
o_gen_sync  out  1  high in IDLE.
o_tx_start  out  1  high in PRIME and STEP.
o_rx_pull  out  1  high in STEP.
o_clock  out  1  gate clock; high in STEP only.
o_busy  out  1  high in any state other than IDLE.
o_done  out  1  one-cycle pulse in DONE.
o_timeout  out  1  sticky timeout flag; cleared by an accepted start.
o_stall_gates  out  GATE_NUMBER  enabled gates not ready when the timeout fired.
o_step_count  out  STEP_W  number of completed steps.

Behaviour:
- States: IDLE, PRIME, WAIT, STEP, DONE. One registered state. o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy and o_done are Moore decodes of the state.
- Reset (asynchronous, mid-operation included): state=IDLE, so o_gen_sync=1 and all other strobes are 0. o_timeout=0, o_stall_gates=0, o_step_count=0, step timer=0, latched configuration=0.
- Configuration latch: i_num_steps, i_timeout and i_gate_en are latched when a start is accepted. Changing these inputs mid-sequence has no effect.
- Ready condition: all_ready = AND over g of ((tx_ready[g] & rx_ready[g]) | ~en[g]). An all-zero mask means always ready.
- IDLE: i_start=1 -> PRIME on the next cycle. Same edge: latch configuration, clear o_step_count, o_timeout and o_stall_gates.
- PRIME: always -> WAIT. PRIME lasts one cycle.
- WAIT:
  - The timer clears on entry and increments every WAIT cycle.
  - all_ready -> STEP.
  - Else, if timeout ≠ 0 and timer == timeout-1 -> IDLE. Same edge: o_timeout=1 and o_stall_gates = en & ~(tx_ready & rx_ready).
  - Else stay in WAIT.
  - all_ready wins over timer expiry in the same cycle.
- STEP: one cycle. o_step_count increments on exit, modulo 2^STEP_W.
  - num_steps ≠ 0 and count+1 == num_steps -> DONE.
  - Otherwise -> WAIT.
- DONE: one cycle, o_done=1, then -> IDLE.
- Abort: i_abort in PRIME, WAIT, STEP or DONE -> IDLE on the next edge. No o_done. o_timeout is unchanged. o_step_count holds its value. i_abort has priority over all other transitions.
- i_start outside IDLE is ignored. i_abort in IDLE is ignored. i_start and i_abort together in IDLE: start is accepted.
- Free-run (num_steps=0): the counter wraps 2^STEP_W-1 -> 0 and sequencing continues until abort or timeout.
- Latency: start at cycle 0 -> first STEP at cycle 3 at the earliest. With continuous ready, steps occur every 2 cycles.

Test Plan:
1. Reset -> o_gen_sync=1, o_busy=0, all other strobes 0, o_step_count=0. Assert i_rst mid-WAIT -> IDLE immediately, without waiting for a clock edge.
2. num_steps=3, mask=0xFF, all ready, start at c0 -> PRIME c1, WAIT c2, STEP c3/c5/c7, DONE c8, IDLE c9. o_rx_pull and o_clock high at c3, c5 and c7. o_done at c8. o_step_count=3.
3. mask=8'b0000_0101, gate1 ready tied 0, gates 0 and 2 ready, num_steps=2 -> completes normally with o_done=1 and o_timeout=0.
4. timeout=4, gate2 tx_ready=0, WAIT entered at c2 -> IDLE at c6. o_timeout=1, o_stall_gates=8'b0000_0100, no o_done. A new start clears o_timeout.
5. timeout=4, all_ready rises at c5 (the timer-expiry cycle) -> STEP at c6 and o_timeout stays 0. Separately, abort asserted in WAIT -> IDLE next cycle, no o_done, step count held.
6. STEP_W=4, num_steps=0, all ready -> o_step_count runs 15 -> 0 with no DONE. Sequencing continues until i_abort, then IDLE.
